// File: rtl/contra_input_pkg.sv
// Shared definitions for the player keyboard input path: game states,
// keycode bit positions, PS/2 scan codes and the frame receiver states.
package contra_input_pkg;

  // Game state encodings
  localparam logic [1:0] GS_MENU = 2'd0;
  localparam logic [1:0] GS_PLAY = 2'd1;
  localparam logic [1:0] GS_DEAD = 2'd2;
  localparam logic [1:0] GS_WIN  = 2'd3;

  // Bit positions inside keycode / held bits
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_JUMP  = 4;

  // Scan codes (set 2)
  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BREAK     = 8'hF0;
  localparam logic [7:0] SC_LEFT      = 8'h1C;
  localparam logic [7:0] SC_RIGHT     = 8'h23;
  localparam logic [7:0] SC_UP        = 8'h1D;
  localparam logic [7:0] SC_DOWN      = 8'h1B;
  localparam logic [7:0] SC_JUMP      = 8'h29;
  localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
  localparam logic [7:0] SC_EXT_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT_UP    = 8'h75;
  localparam logic [7:0] SC_EXT_DOWN  = 8'h72;

  // Frame receiver states
  typedef enum logic [1:0] {
    FRM_IDLE  = 2'd0,
    FRM_SHIFT = 2'd1,
    FRM_CHECK = 2'd2
  } frameState_t;

  // True when the 8 data bits plus the parity bit hold an odd number of ones
  function automatic logic oddParity(input logic [8:0] bits);
    return ^bits;
  endfunction

  // One-hot key mask for a make/break code; all zero for unmapped codes.
  // Extended codes (after E0) only map the cursor-block arrows.
  function automatic logic [4:0] mapKey(input logic [7:0] code, input logic ext);
    logic [4:0] m;
    m = 5'b00000;
    if (ext) begin
      case (code)
        SC_EXT_LEFT:  m[KEY_LEFT]  = 1'b1;
        SC_EXT_RIGHT: m[KEY_RIGHT] = 1'b1;
        SC_EXT_UP:    m[KEY_UP]    = 1'b1;
        SC_EXT_DOWN:  m[KEY_DOWN]  = 1'b1;
        default:      m = 5'b00000;
      endcase
    end else begin
      case (code)
        SC_LEFT:  m[KEY_LEFT]  = 1'b1;
        SC_RIGHT: m[KEY_RIGHT] = 1'b1;
        SC_UP:    m[KEY_UP]    = 1'b1;
        SC_DOWN:  m[KEY_DOWN]  = 1'b1;
        SC_JUMP:  m[KEY_JUMP]  = 1'b1;
        default:  m = 5'b00000;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the raw bus, detects keyboard clock
// falling edges, shifts in start/8 data/parity/stop, checks the frame and
// aborts a frame that stalls for TIMEOUT_CYCLES.
module ps2_rx_frame
  import contra_input_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxError
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       clkSync;
  logic [1:0]       dataSync;
  logic             clkPrev;
  logic             fallPulse;
  logic             dataBit;
  frameState_t      state;
  logic [9:0]       shiftReg;
  logic [3:0]       bitCnt;
  logic [CNT_W-1:0] idleCnt;

  assign fallPulse = clkPrev & ~clkSync[1];
  assign dataBit   = dataSync[1];

  // Two-flop synchronizers (idle-high bus) plus delayed clock for edge detect
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[0], ps2_clk};
      dataSync <= {dataSync[0], ps2_data};
      clkPrev  <= clkSync[1];
    end
  end

  // Frame FSM: bits arrive LSB first and shift right, so after the stop bit
  // shiftReg holds {stop, parity, data[7:0]}
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= FRM_IDLE;
      shiftReg <= 10'd0;
      bitCnt   <= 4'd0;
      idleCnt  <= {CNT_W{1'b0}};
      rxByte   <= 8'h00;
      rxValid  <= 1'b0;
      rxError  <= 1'b0;
    end else begin
      rxValid <= 1'b0;
      rxError <= 1'b0;
      case (state)
        FRM_IDLE: begin
          idleCnt <= {CNT_W{1'b0}};
          bitCnt  <= 4'd0;
          if (fallPulse && !dataBit) begin
            shiftReg <= 10'd0;
            state    <= FRM_SHIFT;
          end
        end
        FRM_SHIFT: begin
          if (fallPulse) begin
            idleCnt  <= {CNT_W{1'b0}};
            shiftReg <= {dataBit, shiftReg[9:1]};
            if (bitCnt == 4'd9) begin
              state <= FRM_CHECK;
            end else begin
              bitCnt <= bitCnt + 4'd1;
            end
          end else if (idleCnt == IDLE_LIMIT) begin
            rxError  <= 1'b1;
            shiftReg <= 10'd0;
            state    <= FRM_IDLE;
          end else begin
            idleCnt <= idleCnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        FRM_CHECK: begin
          if (shiftReg[9] && oddParity(shiftReg[8:0])) begin
            rxByte  <= shiftReg[7:0];
            rxValid <= 1'b1;
          end else begin
            rxError <= 1'b1;
          end
          shiftReg <= 10'd0;
          state    <= FRM_IDLE;
        end
        default: begin
          state <= FRM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/player_key_decoder.sv
// Player keyboard decoder: turns accepted PS/2 scan bytes into held-key
// bits (with E0/F0 prefix handling) and presents them as a gated, registered
// keycode with opposing directions cancelled.
module player_key_decoder
  import contra_input_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [1:0] gameState,
  output logic [4:0] keycode,
  output logic       keyPress,
  output logic [7:0] scanByte,
  output logic       scanValid,
  output logic       frameError
);

  logic [4:0] held;
  logic       extPend;
  logic       brkPend;
  logic [4:0] keyMask;
  logic [4:0] resolved;
  logic [4:0] gated;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uRx (
    .Clk     (Clk),
    .Reset   (Reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rxByte  (scanByte),
    .rxValid (scanValid),
    .rxError (frameError)
  );

  assign keyMask = mapKey(scanByte, extPend);

  // Prefix flags and held-bit tracking, one cycle after each accepted byte
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      held    <= 5'b00000;
      extPend <= 1'b0;
      brkPend <= 1'b0;
    end else if (frameError) begin
      extPend <= 1'b0;
      brkPend <= 1'b0;
    end else if (scanValid) begin
      if (scanByte == SC_EXT) begin
        extPend <= 1'b1;
      end else if (scanByte == SC_BREAK) begin
        brkPend <= 1'b1;
      end else begin
        extPend <= 1'b0;
        brkPend <= 1'b0;
        if (brkPend) begin
          held <= held & ~keyMask;
        end else begin
          held <= held | keyMask;
        end
      end
    end
  end

  // Cancel opposing directions and blank everything outside PLAY
  always_comb begin
    resolved = held;
    if (held[KEY_LEFT] && held[KEY_RIGHT]) begin
      resolved[KEY_RIGHT:KEY_LEFT] = 2'b00;
    end else begin
      resolved[KEY_RIGHT:KEY_LEFT] = held[KEY_RIGHT:KEY_LEFT];
    end
    if (held[KEY_UP] && held[KEY_DOWN]) begin
      resolved[KEY_DOWN:KEY_UP] = 2'b00;
    end else begin
      resolved[KEY_DOWN:KEY_UP] = held[KEY_DOWN:KEY_UP];
    end
    if (gameState == GS_PLAY) begin
      gated = resolved;
    end else begin
      gated = 5'b00000;
    end
  end

  // Registered player outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      keycode  <= 5'b00000;
      keyPress <= 1'b0;
    end else begin
      keycode  <= gated;
      keyPress <= |gated;
    end
  end

endmodule
